// File: rtl/ime_csr_pkg.sv
// Shared register map, response codes and per-channel configuration layout
// for the IME AXI-Lite CSR bank.
package ime_csr_pkg;

    localparam int          CHAN_STRIDE = 32'h20;
    localparam logic [4:0]  OFF_CFG0    = 5'h00;
    localparam logic [4:0]  OFF_CFG1    = 5'h04;
    localparam logic [4:0]  OFF_CFG2    = 5'h08;
    localparam logic [4:0]  OFF_STAT    = 5'h0C;
    localparam logic [4:0]  OFF_ERRCNT  = 5'h10;
    localparam int          ADDR_ID     = 32'h400;
    localparam int          ADDR_COMMIT = 32'h404;
    localparam int          ADDR_IRQ_EN = 32'h408;

    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_CFG0,
        SEL_CFG1,
        SEL_CFG2,
        SEL_STAT,
        SEL_ERRCNT,
        SEL_ID,
        SEL_COMMIT,
        SEL_IRQEN
    } csr_sel_e;

    typedef struct packed {
        csr_sel_e   sel;
        logic [2:0] ch;
    } csr_dec_t;

    typedef struct packed {
        logic [4:0]  mode;
        logic        tree;
        logic [7:0]  lut;
        logic [1:0]  pwl;
        logic [11:0] qp;
        logic [11:0] qlog;
        logic [15:0] frame_len;
        logic [15:0] eps;
    } ime_chan_cfg_t;

    localparam int CFG_W = $bits(ime_chan_cfg_t);

    localparam ime_chan_cfg_t CFG_RESET = '{
        mode: 5'b00001, tree: 1'b0, lut: 8'hFF, pwl: 2'b10,
        qp: 12'd15, qlog: 12'd14, frame_len: 16'h1000, eps: 16'h0001
    };

    // A mode is legal for commit only when exactly one bit is set.
    function automatic logic exact1(input logic [4:0] m);
        return (m != 5'd0) && ((m & (m - 5'd1)) == 5'd0);
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = strb[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] cfg0_word(input ime_chan_cfg_t c);
        return {14'd0, c.pwl, c.lut, 2'b00, c.tree, c.mode};
    endfunction

    function automatic logic [31:0] cfg1_word(input ime_chan_cfg_t c);
        return {8'd0, c.qlog, c.qp};
    endfunction

    function automatic logic [31:0] cfg2_word(input ime_chan_cfg_t c);
        return {c.eps, c.frame_len};
    endfunction

    function automatic ime_chan_cfg_t wr_cfg0(input ime_chan_cfg_t c,
                                              input logic [31:0] wd,
                                              input logic [3:0]  st);
        logic [31:0]   w;
        ime_chan_cfg_t r;
        w      = merge_bytes(cfg0_word(c), wd, st);
        r      = c;
        r.mode = w[4:0];
        r.tree = w[5];
        r.lut  = w[15:8];
        r.pwl  = w[17:16];
        return r;
    endfunction

    function automatic ime_chan_cfg_t wr_cfg1(input ime_chan_cfg_t c,
                                              input logic [31:0] wd,
                                              input logic [3:0]  st);
        logic [31:0]   w;
        ime_chan_cfg_t r;
        w      = merge_bytes(cfg1_word(c), wd, st);
        r      = c;
        r.qp   = w[11:0];
        r.qlog = w[23:12];
        return r;
    endfunction

    function automatic ime_chan_cfg_t wr_cfg2(input ime_chan_cfg_t c,
                                              input logic [31:0] wd,
                                              input logic [3:0]  st);
        logic [31:0]   w;
        ime_chan_cfg_t r;
        w           = merge_bytes(cfg2_word(c), wd, st);
        r           = c;
        r.frame_len = w[15:0];
        r.eps       = w[31:16];
        return r;
    endfunction

endpackage

// File: rtl/ime_csr_chan.sv
// One IME channel: shadow/active configuration with commit, sticky status
// and saturating error counter.
module ime_csr_chan
    import ime_csr_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      wdata_i,
    input  logic [3:0]       wstrb_i,
    input  logic             wr_cfg0_i,
    input  logic             wr_cfg1_i,
    input  logic             wr_cfg2_i,
    input  logic             wr_stat_i,
    input  logic             wr_errcnt_i,
    input  logic             commit_i,
    input  logic             frame_start_i,
    input  logic [3:0]       error_flags_i,
    output logic [CFG_W-1:0] active_o,
    output logic [31:0]      cfg0_o,
    output logic [31:0]      cfg1_o,
    output logic [31:0]      cfg2_o,
    output logic [31:0]      stat_o,
    output logic [31:0]      errcnt_o,
    output logic             cfg_applied_o,
    output logic             irq_src_o
);

    ime_chan_cfg_t    shadow_q, shadow_d;
    ime_chan_cfg_t    active_q, active_d;
    logic             pend_q, pend_d;
    logic [3:0]       err_q, err_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             applied_q, applied_d;
    logic [4:0]       clr;
    logic             req;
    logic             any_err;

    always_comb begin
        shadow_d  = shadow_q;
        active_d  = active_q;
        pend_d    = pend_q;
        applied_d = 1'b0;
        cnt_d     = cnt_q;
        clr       = (wr_stat_i && wstrb_i[0]) ? wdata_i[4:0] : 5'd0;
        any_err   = |error_flags_i;

        if (wr_cfg0_i) shadow_d = wr_cfg0(shadow_q, wdata_i, wstrb_i);
        if (wr_cfg1_i) shadow_d = wr_cfg1(shadow_q, wdata_i, wstrb_i);
        if (wr_cfg2_i) shadow_d = wr_cfg2(shadow_q, wdata_i, wstrb_i);

        // New error pulses are ORed after the clear so a coincident set wins.
        err_d     = (err_q & ~clr[3:0]) | error_flags_i;
        cfg_err_d = cfg_err_q & ~clr[4];

        req = pend_q | commit_i;
        if (req && frame_start_i) begin
            pend_d = 1'b0;
            if (exact1(shadow_q.mode)) begin
                active_d  = shadow_q;
                applied_d = 1'b1;
            end else begin
                cfg_err_d = 1'b1;
            end
        end else begin
            pend_d = req;
        end

        if (wr_errcnt_i)
            cnt_d = any_err ? CNT_W'(1) : '0;
        else if (any_err && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= CFG_RESET;
            active_q  <= CFG_RESET;
            pend_q    <= 1'b0;
            err_q     <= 4'd0;
            cfg_err_q <= 1'b0;
            cnt_q     <= '0;
            applied_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            cfg_err_q <= cfg_err_d;
            cnt_q     <= cnt_d;
            applied_q <= applied_d;
        end
    end

    assign active_o      = active_q;
    assign cfg0_o        = cfg0_word(shadow_q);
    assign cfg1_o        = cfg1_word(shadow_q);
    assign cfg2_o        = cfg2_word(shadow_q);
    assign stat_o        = {26'd0, pend_q, cfg_err_q, err_q};
    assign errcnt_o      = 32'(cnt_q);
    assign cfg_applied_o = applied_q;
    assign irq_src_o     = (|err_q) | cfg_err_q;

endmodule

// File: rtl/ime_axi_lite_csr_bank.sv
// AXI-Lite front end of the IME CSR bank: handshakes, address decode,
// read mux, interrupt enable and per-channel configuration outputs.
module ime_axi_lite_csr_bank
    import ime_csr_pkg::*;
#(
    parameter int          N_CH    = 4,
    parameter int          ADDR_W  = 16,
    parameter int          CNT_W   = 16,
    parameter logic [31:0] VERSION = 32'h0002_0000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    s_axi_awaddr,
    input  logic                 s_axi_awvalid,
    output logic                 s_axi_awready,
    input  logic [31:0]          s_axi_wdata,
    input  logic [3:0]           s_axi_wstrb,
    input  logic                 s_axi_wvalid,
    output logic                 s_axi_wready,
    output logic [1:0]           s_axi_bresp,
    output logic                 s_axi_bvalid,
    input  logic                 s_axi_bready,
    input  logic [ADDR_W-1:0]    s_axi_araddr,
    input  logic                 s_axi_arvalid,
    output logic                 s_axi_arready,
    output logic [31:0]          s_axi_rdata,
    output logic [1:0]           s_axi_rresp,
    output logic                 s_axi_rvalid,
    input  logic                 s_axi_rready,
    input  logic [N_CH-1:0]      frame_start,
    input  logic [N_CH*4-1:0]    error_flags,
    output logic [N_CH*5-1:0]    mode_onehot,
    output logic [N_CH-1:0]      tree_type,
    output logic [N_CH*8-1:0]    lut_size_cfg,
    output logic [N_CH*2-1:0]    pwl_segments_cfg,
    output logic [N_CH*12-1:0]   qp_frac,
    output logic [N_CH*12-1:0]   qlog_frac,
    output logic [N_CH*16-1:0]   frame_len,
    output logic [N_CH*16-1:0]   epsilon_q,
    output logic [N_CH-1:0]      cfg_applied,
    output logic                 irq
);

    logic              aw_held_q, w_held_q, bvalid_q, rvalid_q, irq_q;
    logic [1:0]        bresp_q, rresp_q;
    logic [ADDR_W-3:0] aw_word_q;
    logic [31:0]       wdata_q, rdata_q;
    logic [3:0]        wstrb_q;
    logic [N_CH-1:0]   irq_en_q;

    logic              wr_go, wr_err, ar_hs;
    csr_dec_t          wdec, rdec;
    logic [31:0]       rd_data;
    logic [1:0]        rd_resp;
    logic [N_CH-1:0]   irq_src;
    logic [31:0]       cfg0_w [N_CH];
    logic [31:0]       cfg1_w [N_CH];
    logic [31:0]       cfg2_w [N_CH];
    logic [31:0]       stat_w [N_CH];
    logic [31:0]       cnt_w  [N_CH];
    logic [CFG_W-1:0]  active_w [N_CH];
    logic [3:0]        unused_lsbs;

    // Byte offset within the word never affects decode.
    assign unused_lsbs = {s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    function automatic csr_dec_t decode(input logic [ADDR_W-3:0] word);
        logic [ADDR_W-1:0] a;
        csr_dec_t          d;
        a     = {word, 2'b00};
        d.sel = SEL_NONE;
        d.ch  = '0;
        if (a < ADDR_W'(N_CH * CHAN_STRIDE)) begin
            d.ch = a[7:5];
            case (a[4:0])
                OFF_CFG0:   d.sel = SEL_CFG0;
                OFF_CFG1:   d.sel = SEL_CFG1;
                OFF_CFG2:   d.sel = SEL_CFG2;
                OFF_STAT:   d.sel = SEL_STAT;
                OFF_ERRCNT: d.sel = SEL_ERRCNT;
                default:    d.sel = SEL_NONE;
            endcase
        end else if (a == ADDR_W'(ADDR_ID)) begin
            d.sel = SEL_ID;
        end else if (a == ADDR_W'(ADDR_COMMIT)) begin
            d.sel = SEL_COMMIT;
        end else if (a == ADDR_W'(ADDR_IRQ_EN)) begin
            d.sel = SEL_IRQEN;
        end
        return d;
    endfunction

    assign wdec   = decode(aw_word_q);
    assign rdec   = decode(s_axi_araddr[ADDR_W-1:2]);
    assign wr_go  = aw_held_q & w_held_q & ~bvalid_q;
    assign wr_err = (wdec.sel == SEL_NONE) || (wdec.sel == SEL_ID);
    assign ar_hs  = s_axi_arvalid & ~rvalid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            if (s_axi_awvalid && !aw_held_q) aw_held_q <= 1'b1;
            if (s_axi_wvalid && !w_held_q)   w_held_q  <= 1'b1;
            if (wr_go) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && s_axi_bready) begin
                bvalid_q  <= 1'b0;
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end
            if (wr_go && (wdec.sel == SEL_IRQEN) && wstrb_q[0])
                irq_en_q <= wdata_q[N_CH-1:0];
            if (ar_hs)
                rvalid_q <= 1'b1;
            else if (rvalid_q && s_axi_rready)
                rvalid_q <= 1'b0;
            irq_q <= |(irq_src & irq_en_q);
        end
    end

    always_ff @(posedge clk) begin
        if (s_axi_awvalid && !aw_held_q) aw_word_q <= s_axi_awaddr[ADDR_W-1:2];
        if (s_axi_wvalid && !w_held_q) begin
            wdata_q <= s_axi_wdata;
            wstrb_q <= s_axi_wstrb;
        end
        if (ar_hs) begin
            rdata_q <= rd_data;
            rresp_q <= rd_resp;
        end
    end

    always_comb begin
        rd_data = 32'd0;
        rd_resp = RESP_OKAY;
        case (rdec.sel)
            SEL_NONE:   rd_resp = RESP_SLVERR;
            SEL_ID:     rd_data = VERSION;
            SEL_COMMIT: rd_data = 32'd0;
            SEL_IRQEN:  rd_data = 32'(irq_en_q);
            default: begin
                for (int c = 0; c < N_CH; c++) begin
                    if (rdec.ch == 3'(c)) begin
                        case (rdec.sel)
                            SEL_CFG0:   rd_data = cfg0_w[c];
                            SEL_CFG1:   rd_data = cfg1_w[c];
                            SEL_CFG2:   rd_data = cfg2_w[c];
                            SEL_STAT:   rd_data = stat_w[c];
                            SEL_ERRCNT: rd_data = cnt_w[c];
                            default:    rd_data = 32'd0;
                        endcase
                    end
                end
            end
        endcase
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic          hit;
        ime_chan_cfg_t act;

        assign hit = wr_go && (wdec.ch == 3'(c));
        assign act = active_w[c];

        ime_csr_chan #(.CNT_W(CNT_W)) u_chan (
            .clk           (clk),
            .rst_n         (rst_n),
            .wdata_i       (wdata_q),
            .wstrb_i       (wstrb_q),
            .wr_cfg0_i     (hit && (wdec.sel == SEL_CFG0)),
            .wr_cfg1_i     (hit && (wdec.sel == SEL_CFG1)),
            .wr_cfg2_i     (hit && (wdec.sel == SEL_CFG2)),
            .wr_stat_i     (hit && (wdec.sel == SEL_STAT)),
            .wr_errcnt_i   (hit && (wdec.sel == SEL_ERRCNT)),
            .commit_i      (wr_go && (wdec.sel == SEL_COMMIT) && wstrb_q[0] && wdata_q[c]),
            .frame_start_i (frame_start[c]),
            .error_flags_i (error_flags[c*4 +: 4]),
            .active_o      (active_w[c]),
            .cfg0_o        (cfg0_w[c]),
            .cfg1_o        (cfg1_w[c]),
            .cfg2_o        (cfg2_w[c]),
            .stat_o        (stat_w[c]),
            .errcnt_o      (cnt_w[c]),
            .cfg_applied_o (cfg_applied[c]),
            .irq_src_o     (irq_src[c])
        );

        assign mode_onehot[c*5 +: 5]       = act.mode;
        assign tree_type[c]                = act.tree;
        assign lut_size_cfg[c*8 +: 8]      = act.lut;
        assign pwl_segments_cfg[c*2 +: 2]  = act.pwl;
        assign qp_frac[c*12 +: 12]         = act.qp;
        assign qlog_frac[c*12 +: 12]       = act.qlog;
        assign frame_len[c*16 +: 16]       = act.frame_len;
        assign epsilon_q[c*16 +: 16]       = act.eps;
    end

    assign s_axi_awready = ~aw_held_q;
    assign s_axi_wready  = ~w_held_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = ~rvalid_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign irq           = irq_q;

endmodule

// File: doc/ime_axi_lite_csr_bank.md
# ime_axi_lite_csr_bank

Multi-channel AXI-Lite control/status register bank for the IME pipeline. It serves N_CH independent IME channels, each with its own configuration and status registers. Configuration is double-buffered: software writes a shadow copy, and the active copy changes only on an atomic commit (software-triggered or at a frame boundary), with EXACT1 mode checking applied at commit. It adds byte strobes, SLVERR decode, independent AW/W acceptance, sticky status with saturating error counters, and a level interrupt.

## Interface
- N_CH, 4, number of channels (1..8)
- ADDR_W, 16, AXI address width
- CNT_W, 16, per-channel error counter width (≤32)
- VERSION, 32'h0002_0000, value returned by the ID register
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- s_axi_aw{addr[ADDR_W],valid,ready}, s_axi_w{data[32],strb[4],valid,ready}, s_axi_b{resp[2],valid,ready}  AXI-Lite write channels (directions per AXI slave)
- s_axi_ar{addr[ADDR_W],valid,ready}, s_axi_r{data[32],resp[2],valid,ready}  AXI-Lite read channels
- frame_start  in  N_CH  per-channel frame boundary strobe (commit point)
- error_flags  in  N_CH*4  per-channel error pulses
- mode_onehot  out  N_CH*5  active mode per channel
- tree_type  out  N_CH  active tree type
- lut_size_cfg  out  N_CH*8  active LUT size
- pwl_segments_cfg  out  N_CH*2  active PWL segment count
- qp_frac, qlog_frac  out  N_CH*12 each  active fractional widths
- frame_len, epsilon_q  out  N_CH*16 each  active frame length and epsilon
- cfg_applied  out  N_CH  one-cycle pulse when the active copy updates
- irq  out  1  level interrupt

## Operation
- Channel c base address = c*0x20. Offsets:
  - 0x00 CFG0 RW shadow: mode[4:0], tree[5], lut[15:8], pwl[17:16]
  - 0x04 CFG1 RW shadow: qp[11:0], qlog[23:12]
  - 0x08 CFG2 RW shadow: frame_len[15:0], eps[31:16]
  - 0x0C STAT: err[3:0] W1C sticky; cfg_err[4] W1C; pend[5] RO
  - 0x10 ERRCNT: RO, saturating; any write clears it
- Global registers:
  - 0x400 ID: RO, returns VERSION
  - 0x404 COMMIT: WO; bit c requests a commit on channel c; reads return 0
  - 0x408 IRQ_EN: RW, bits [N_CH-1:0]
- Decode errors return SLVERR (2'b10):
  - Unmapped address, channel index ≥ N_CH, or a write to ID gives SLVERR; the write has no effect and a read returns 0.
  - Addresses are word-aligned; addr[1:0] is ignored.
- wstrb gates each byte lane of RW fields. For W1C and COMMIT, a bit acts only when its lane is strobed.
- Commit handling:
  - A COMMIT bit sets pend[c]. The commit executes on the next frame_start[c], or in the same cycle if frame_start[c] is already high.
  - On execute: if the shadow mode is EXACT1, all shadow fields copy to active and cfg_applied[c] pulses. Otherwise nothing copies, cfg_err sets, and cfg_applied stays low.
  - Either way, pend clears.
  - A COMMIT write while pend is already set is idempotent.
- Status handling:
  - err[c] |= error_flags each cycle.
  - If W1C and a new error hit the same bit in the same cycle, the bit stays set (set wins).
  - ERRCNT increments by 1 for every cycle in which any error_flags bit of the channel is high, saturating at all-ones. If a clear and an increment coincide, the result is 1.
- irq = OR over c of ((|err[c] | cfg_err[c]) & IRQ_EN[c]).
- Reset values:
  - Shadow and active: mode 5'b00001, tree 0, lut 8'hFF, pwl 2'b10, qp 15, qlog 14, frame_len 16'h1000, eps 16'h0001.
  - Status, ERRCNT, pend, and IRQ_EN are 0.
  - irq, cfg_applied, bvalid, and rvalid are 0; awready, wready, and arready are 1.
- A reset in the middle of a transaction aborts it. No response is issued after reset.

## Timing
- Write path:
  - AW and W are each captured into a one-entry holding register. awready = !aw_held and wready = !w_held; AW and W may arrive in either order or in the same cycle.
  - Once both are held, the register update occurs on the next edge and bvalid asserts on that same edge.
  - Both holding registers free when bvalid && bready. The minimum turnaround from AW/W acceptance to bvalid is 1 cycle.
  - bvalid/bresp hold stable until bready.
- Read path:
  - arready = !rvalid. Read data is registered: rvalid asserts the cycle after the AR handshake, and rdata/rresp hold until rready.
  - Read data is sampled at AR acceptance. A read issued in the same cycle as a write to the same register returns the old value.
- Active outputs and cfg_applied change on the edge where the commit executes. There is no combinational path from AXI inputs to configuration outputs.
- irq is registered: 1 cycle after the status bit sets.

## Structure
- Package ime_csr_pkg holds:
  - offset constants, CHAN_STRIDE, and global addresses
  - the RESP_OKAY/RESP_SLVERR constants
  - the ime_chan_cfg_t packed struct for the shadow/active field set
  - an exact1 function
- Sub-module ime_csr_chan is instantiated N_CH times. It owns the shadow, active, pend, status, and ERRCNT registers for one channel, plus its commit logic.
- The top level owns the AXI handshakes, address decode, read mux, IRQ_EN, and irq.

## Test plan
- Write CFG0=0x0002_FF04 to ch1 with wstrb=4'hF, then read it back: OKAY and 0x0002_FF04. mode_onehot ch1 stays 5'b00001 until a commit.
- COMMIT=0x2 followed by frame_start[1] 3 cycles later: pend reads 1 in the meantime. mode ch1 becomes 5'b00100 and cfg_applied[1] pulses on the frame_start edge.
- Shadow mode 5'b00110 plus commit with frame_start already high: active config is unchanged, cfg_err=1, and with IRQ_EN[c]=1, irq=1 one cycle later.
- W issued 2 cycles before AW to 0x0C0 (channel 6 when N_CH=4): bresp=SLVERR with no state change. A read of 0x400 returns VERSION/OKAY; a read of 0x414 returns 0/SLVERR.
- error_flags ch0=4'h1 held for 3 cycles, with a W1C of STAT bit0 on the second cycle: err[0] stays 1 and ERRCNT=3. Saturation check with CNT_W=4: 20 error cycles give 15.
- wstrb=4'h2 write of 0xFFFF_FFFF to CFG1 ch0: only bits [15:8] change. With bready held low for 5 cycles, bvalid stays high, and awready/wready stay low until the handshake completes.
